score_sequencer: RTL and testbench
==================================

Name: score_sequencer

Overview:
Controller that streams one Gaussian's per-dimension operands (feature, mean, precision) from three parallel operand RAMs into the free-running, non-stallable score datapath (subtract, square, multiply by precision).
- Tracks in-flight dimensions with a tag shift register matching the datapath latency.
- Captures each emerging logDval into a result FIFO.
- Presents results downstream as an AXI-Stream-style interface with index and last flag.
- Credit-based issue guarantees the FIFO never overflows under downstream backpressure.

Parameters:
SCORE_LAT, 20, clock latency of the score datapath from operand inputs to logDval output
MEM_LAT, 1, read latency of the operand RAMs (rd_en/addr to data)
ADDR_W, 10, operand RAM address width
DIM_W, 10, width of the dimension count and index
FIFO_DEPTH, 32, result FIFO entries; must be >= 2 (elaboration error otherwise)

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to score one Gaussian; honoured only in IDLE
cfg_base  in  ADDR_W  first operand address
cfg_dims  in  DIM_W  number of dimensions to process
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the job completes
mem_rd_en  out  1  operand RAM read strobe (shared by all three RAMs)
mem_addr  out  ADDR_W  operand RAM address
mem_feature  in  32  feature word, valid MEM_LAT cycles after rd_en
mem_mean  in  32  mean word
mem_prec  in  32  precision word
su_feature  out  32  score datapath feature input (= mem_feature)
su_mean  out  32  score datapath mean input (= mem_mean)
su_prec  out  32  score datapath precision input (= mem_prec)
su_logDval  in  32  score datapath result
res_tvalid  out  1  result available
res_tready  in  1  downstream accepts result
res_tdata  out  32  logDval for one dimension
res_tuser  out  DIM_W  dimension index 0..cfg_dims-1
res_tlast  out  1  high on the final dimension's result

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, res_tvalid=0, res_tlast=0, res_tuser=0, res_tdata=0. FIFO empty, tag pipe cleared, state IDLE.
- Reset mid-job: in-flight tags and FIFO contents are discarded; no partial results appear after reset.
- su_* are combinational pass-throughs of mem_*. Data is meaningful only in tagged slots.
- Tag pipe: length MEM_LAT+SCORE_LAT. Each entry holds {valid, index, last}.
  - Issue at cycle t pushes valid=1; non-issue pushes valid=0.
  - When a valid tag exits at cycle t+MEM_LAT+SCORE_LAT, {su_logDval, index, last} is written to the FIFO that same edge.
- Credit rule: issue permitted only when fifo_count + inflight + 1 <= FIFO_DEPTH, where inflight = valid tags in the pipe. Pop and exit in the same cycle are counted correctly. FIFO overflow is therefore unreachable.
- FIFO: first-word-fall-through. res_tvalid = not empty. Pop on res_tvalid && res_tready. Simultaneous push and pop on a full or empty FIFO is legal. Order is strictly index order.
- State machine:
  - IDLE:
    - start with cfg_dims!=0: latch base and dims, index=0, busy=1, go to RUN.
    - start with cfg_dims==0: done pulses next cycle, busy stays 0, no results, stay IDLE.
  - RUN: each cycle the credit rule allows, assert mem_rd_en with mem_addr=base+index and push the tag (last = index==dims-1); index++. After issuing the last index, go to DRAIN.
  - DRAIN: no issue. Wait until the pipe is empty, the FIFO is empty, and the final pop (tlast) has occurred; then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- start in any state other than IDLE is ignored; latched config is unchanged.
- Address arithmetic wraps modulo 2^ADDR_W.
- Throughput: one dimension per cycle while res_tready is held high. First result is valid MEM_LAT+SCORE_LAT+1 cycles after the start edge.

Test Plan:
- SCORE_LAT=4, cfg_base=0x10, cfg_dims=4, res_tready=1; RAM holds feature=3.0, mean=1.0, prec=0.5 in every entry; real datapath. Required: 4 results, each 0x40000000; tuser 0,1,2,3; tlast only on index 3; done pulse one cycle after the tlast handshake; mem_addr 0x10..0x13 on consecutive cycles.
- cfg_dims=64, res_tready=0 for cycles 0..80 then 1. Required: issue stops once FIFO_DEPTH credits are used; no overflow; all 64 results in order with correct indices.
- cfg_dims=0. Required: done pulses once, busy never rises, res_tvalid stays 0, mem_rd_en stays 0.
- start pulsed again during RUN with different cfg. Required: ignored; original job completes with the original dims.
- aresetn asserted mid-DRAIN with 3 results queued. Required: all outputs return to reset values immediately; after release no stale results appear; a new job then runs correctly.
- cfg_base=2^ADDR_W-2, cfg_dims=4. Required: addresses wrap 0x3FE, 0x3FF, 0x000, 0x001.

Source files
------------

// File: rtl/score_sequencer.sv
// Operand sequencer for the Gaussian score datapath: issues RAM reads under a FIFO credit
// limit, tags each slot through the fixed datapath latency and streams results out in order.
module score_sequencer #(
    parameter int SCORE_LAT  = 20,
    parameter int MEM_LAT    = 1,
    parameter int ADDR_W     = 10,
    parameter int DIM_W      = 10,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_dims,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_feature,
    input  logic [31:0]       mem_mean,
    input  logic [31:0]       mem_prec,
    output logic [31:0]       su_feature,
    output logic [31:0]       su_mean,
    output logic [31:0]       su_prec,
    input  logic [31:0]       su_logDval,
    output logic              res_tvalid,
    input  logic              res_tready,
    output logic [31:0]       res_tdata,
    output logic [DIM_W-1:0]  res_tuser,
    output logic              res_tlast
);
    localparam int PIPE_LEN = MEM_LAT + SCORE_LAT;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    generate
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("score_sequencer: FIFO_DEPTH must be >= 2");
        end
        if (PIPE_LEN < 2) begin : g_bad_lat
            $error("score_sequencer: MEM_LAT + SCORE_LAT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef struct packed { logic [DIM_W-1:0] idx; logic last; } tag_t;
    typedef struct packed { logic [31:0] data; logic [DIM_W-1:0] idx; logic last; } res_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  dims_q, idx_q;

    logic [PIPE_LEN-1:0] vld_pipe;
    tag_t                tag_pipe [PIPE_LEN];
    logic [CNT_W-1:0]    inflight;

    res_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    res_t             head;

    logic           issue, last_iss, push, pop, credit_ok;
    logic [CNT_W:0] credit_sum;

    // Exit moves a slot from inflight to fifo_cnt, so the sum only drops on pop.
    assign credit_sum = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(inflight) + (CNT_W+1)'(1);
    assign credit_ok  = credit_sum <= (CNT_W+1)'(FIFO_DEPTH);
    assign issue      = (state_q == S_RUN) && credit_ok;
    assign last_iss   = idx_q == dims_q - DIM_W'(1);
    assign push       = vld_pipe[PIPE_LEN-1];
    assign pop        = res_tvalid && res_tready;
    assign head       = fifo_mem[rd_ptr];

    assign mem_rd_en  = issue;
    assign mem_addr   = base_q + ADDR_W'(idx_q);
    assign su_feature = mem_feature;
    assign su_mean    = mem_mean;
    assign su_prec    = mem_prec;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = state_q == S_DONE;

    assign res_tvalid = fifo_cnt != '0;
    assign res_tdata  = res_tvalid ? head.data : '0;
    assign res_tuser  = res_tvalid ? head.idx  : '0;
    assign res_tlast  = res_tvalid && head.last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (cfg_dims != '0) ? S_RUN : S_DONE;
            S_RUN:   if (issue && last_iss) state_d = S_DRAIN;
            // The tlast pop is the final handshake: nothing remains behind it.
            S_DRAIN: if (pop && head.last && inflight == '0 && fifo_cnt == CNT_W'(1))
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            dims_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start && cfg_dims != '0) begin
                base_q <= cfg_base;
                dims_q <= cfg_dims;
                idx_q  <= '0;
            end else if (issue) begin
                idx_q <= idx_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_pipe <= '0;
            inflight <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LEN-2:0], issue};
            inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
        end
    end

    always_ff @(posedge aclk) begin
        tag_pipe[0] <= '{idx: idx_q, last: last_iss};
        for (int i = 1; i < PIPE_LEN; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{data: su_logDval,
                                  idx:  tag_pipe[PIPE_LEN-1].idx,
                                  last: tag_pipe[PIPE_LEN-1].last};
    end
endmodule

// File: tb/tb_score_sequencer.sv
// Randomized bench for score_sequencer: operand RAMs, a float score datapath and an
// in-order expected-result queue built directly from RAM contents.
module tb_score_sequencer;
    localparam int SL = 4, ML = 1, AW = 10, DW = 10, FD = 32;
    localparam int L  = SL + ML;

    logic          aclk = 0, aresetn = 0, start = 0, res_tready = 0;
    logic [AW-1:0] cfg_base = '0;
    logic [DW-1:0] cfg_dims = '0;
    logic          busy, done, mem_rd_en, res_tvalid, res_tlast;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_feature, mem_mean, mem_prec, su_feature, su_mean, su_prec;
    logic [31:0]   su_logDval, res_tdata;
    logic [DW-1:0] res_tuser;

    score_sequencer #(.SCORE_LAT(SL), .MEM_LAT(ML), .ADDR_W(AW), .DIM_W(DW), .FIFO_DEPTH(FD)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .cfg_base(cfg_base), .cfg_dims(cfg_dims),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_feature(mem_feature), .mem_mean(mem_mean), .mem_prec(mem_prec),
        .su_feature(su_feature), .su_mean(su_mean), .su_prec(su_prec), .su_logDval(su_logDval),
        .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tdata(res_tdata),
        .res_tuser(res_tuser), .res_tlast(res_tlast));

    always #5 aclk = ~aclk;

    int vec_cnt = 0, err_cnt = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] score(input logic [31:0] f, m, p);
        real x;
        x = f2r(f) - f2r(m);
        return r2f(x * x * f2r(p));
    endfunction

    function automatic logic [31:0] rnd_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // Operand RAMs and the score datapath sit outside the DUT.
    logic [31:0] ram_f [1024], ram_m [1024], ram_p [1024];
    logic [31:0] dp [SL];
    always @(posedge aclk) if (mem_rd_en) begin
        mem_feature <= ram_f[mem_addr];
        mem_mean    <= ram_m[mem_addr];
        mem_prec    <= ram_p[mem_addr];
    end
    always @(posedge aclk) begin
        dp[0] <= score(su_feature, su_mean, su_prec);
        for (int i = 1; i < SL; i++) dp[i] <= dp[i-1];
    end
    assign su_logDval = dp[SL-1];
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct { logic [31:0] d; int idx; bit last; } exp_t;
    exp_t expq[$];
    exp_t e_mon;
    bit   job_on = 0, done_due = 0, done_seen = 0, tv_seen = 0, nd;
    int   job_base = 0, issued = 0, popped = 0, first_tv = 0, first_iss = 0, last_iss = 0;

    always @(negedge aclk) begin
        if (!aresetn) done_due = 0;
        else begin
            if (mem_rd_en) begin
                chk("rd_en_in_job", job_on, 1);
                chk("mem_addr", mem_addr, (job_base + issued) % 1024);
                if (issued == 0) first_iss = cyc;
                last_iss = cyc;
                issued++;
                chk("credit", (issued - popped) <= FD, 1);
            end
            if (!job_on) begin
                chk("busy_idle", busy, 0);
                chk("tvalid_idle", res_tvalid, 0);
            end
            if (res_tvalid && !tv_seen) begin tv_seen = 1; first_tv = cyc; end
            nd = 0;
            if (res_tvalid && res_tready) begin
                if (expq.size() == 0) chk("spurious_result", 1, 0);
                else begin
                    e_mon = expq.pop_front();
                    chk("tdata", res_tdata, e_mon.d);
                    chk("tuser", res_tuser, e_mon.idx);
                    chk("tlast", res_tlast, e_mon.last);
                    nd = e_mon.last;
                end
                popped++;
            end
            if (start && cfg_dims == 0 && !job_on) nd = 1;
            chk("done", done, done_due);
            if (done) begin chk("busy_at_done", busy, 0); done_seen = 1; end
            done_due = nd;
        end
    end

    task automatic load_expect(input int base, input int dims);
        for (int i = 0; i < dims; i++) begin
            int a;
            a = (base + i) % 1024;
            expq.push_back('{score(ram_f[a], ram_m[a], ram_p[a]), i, i == dims - 1});
        end
        job_base = base; issued = 0; popped = 0; tv_seen = 0; done_seen = 0;
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for 81 cycles then high
    task automatic run_job(input int base, input int dims, input int mode,
                           input int restart_at, input bit chk_lat);
        int n, cs;
        load_expect(base, dims);
        @(posedge aclk); #1;
        cfg_base = AW'(base); cfg_dims = DW'(dims); start = 1; job_on = (dims != 0);
        @(posedge aclk); #1;
        cs = cyc; start = 0; cfg_base = AW'($urandom); cfg_dims = DW'($urandom);
        if (dims != 0) chk("busy_rise", busy, 1);
        n = 0;
        while (!done_seen && n < 5000) begin
            case (mode)
                0:       res_tready = 1;
                1:       res_tready = 1'($urandom_range(0, 1));
                default: res_tready = (n > 80);
            endcase
            if (mode == 2 && n == 80) chk("stall_issue_cap", issued, FD);
            if (n == restart_at) begin
                start = 1; cfg_base = AW'($urandom); cfg_dims = DW'(dims + 7);
            end else start = 0;
            @(posedge aclk); #1;
            n++;
        end
        start = 0;
        chk("job_done", done_seen, 1);
        chk("queue_empty", expq.size(), 0);
        chk("issue_count", issued, dims);
        if (chk_lat) begin
            chk("first_latency", first_tv - cs, L + 1);
            chk("issue_burst", last_iss - first_iss, dims - 1);
        end
        job_on = 0;
        expq.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_tvalid"}, res_tvalid, 0);
        chk({tag, "_tlast"}, res_tlast, 0);
        chk({tag, "_tuser"}, res_tuser, 0);
        chk({tag, "_tdata"}, res_tdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_f[i] = 32'h40400000; ram_m[i] = 32'h3F800000; ram_p[i] = 32'h3F000000;
        end
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;

        run_job(16'h10, 4, 0, -1, 1);
        run_job(5, 0, 0, -1, 0);
        run_job(1022, 4, 0, -1, 1);

        for (int i = 0; i < 1024; i++) begin
            ram_f[i] = rnd_float(); ram_m[i] = rnd_float(); ram_p[i] = rnd_float();
        end
        run_job($urandom_range(0, 1023), 64, 2, -1, 0);
        run_job($urandom_range(0, 1023), 20, 1, 3, 0);

        // Reset while draining with three results queued.
        load_expect(100, 3);
        @(posedge aclk); #1;
        cfg_base = 100; cfg_dims = 3; start = 1; job_on = 1; res_tready = 0;
        @(posedge aclk); #1 start = 0;
        repeat (L + 8) @(posedge aclk);
        #1 chk("pre_reset_tvalid", res_tvalid, 1);
        chk("pre_reset_busy", busy, 1);
        aresetn = 0;
        #1 chk_reset_outputs("mid_reset");
        expq.delete(); job_on = 0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1; res_tready = 1;
        repeat (20) @(posedge aclk);

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 1023), $urandom_range(1, 70), $urandom_range(0, 1), -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
